// File: rtl/microwave_button_conditioner.sv
// -----------------------------------------------------------------------------
// microwave_button_conditioner
//
// Purpose: front-end conditioner for the microwave control logic. The four raw
// push-buttons and the door switch are each passed through a 2-flop
// synchronizer and a debouncer. A button turns into a single-cycle press pulse
// when its debounced level rises. The door turns into a debounced level.
//
// Optional feature macro: BTN_AUTOREPEAT_EN
//   defined   -> btnU and btnD auto-repeat while held: the first repeat comes
//                REPEAT_DELAY cycles after the press pulse, and later repeats
//                come every REPEAT_RATE cycles.
//   undefined -> one pulse per accepted press on every button. REPEAT_DELAY
//                and REPEAT_RATE have no effect.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change (>= 2)
//   REPEAT_DELAY     cycles from the press pulse to the first repeat pulse
//   REPEAT_RATE      cycles between later repeat pulses (>= 2)
//
// Ports:
//   clk              system clock (single domain)
//   reset            asynchronous, active-high
//   btn{U,L,C,D}_raw raw button pins, active-high, asynchronous
//   door_raw         raw door switch, 1 = open, asynchronous
//   btn{U,L,C,D}     registered single-cycle press pulses
//   door             debounced door level
//   btn_held         debounced button levels, ordered {U, L, C, D}
// -----------------------------------------------------------------------------
module microwave_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnU_raw,
    input  logic       btnL_raw,
    input  logic       btnC_raw,
    input  logic       btnD_raw,
    input  logic       door_raw,
    output logic       btnU,
    output logic       btnL,
    output logic       btnC,
    output logic       btnD,
    output logic       door,
    output logic [3:0] btn_held
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Channel index map: 4 = U, 3 = L, 2 = C, 1 = D, 0 = door.
    logic [4:0] raw_vec;
    logic [4:0] sync_vec;
    logic [4:0] stable;
    logic [4:0] accept;
    logic [4:0] rise;
    logic [4:0] fall;
    logic [1:0] rep_fire;   // [1] = U, [0] = D
    logic [3:0] press_q;
    logic       unused_sig;

    assign raw_vec = {btnU_raw, btnL_raw, btnC_raw, btnD_raw, door_raw};

    for (genvar i = 0; i < 5; i++) begin : g_ch
        logic          s1;
        logic          s2;
        logic          stable_q;
        logic [CW-1:0] cnt;
        logic          differ;

        assign differ = (s2 != stable_q);

        // Whenever the synchronized input matches the accepted level, the
        // counter clears. A glitch shorter than DEBOUNCE_CYCLES therefore
        // leaves nothing behind.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1       <= 1'b0;
                s2       <= 1'b0;
                stable_q <= 1'b0;
                cnt      <= '0;
            end else begin
                s1 <= raw_vec[i];
                s2 <= s1;
                if (!differ) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    stable_q <= s2;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign sync_vec[i] = s2;
        assign stable[i]   = stable_q;
        assign accept[i]   = differ && (cnt == DB_LAST);
    end

    // rise/fall mark the edge at which a channel's stable level changes.
    assign rise = accept & sync_vec;
    assign fall = accept & ~sync_vec;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX);

    typedef enum logic {
        PH_DELAY = 1'b0,
        PH_RATE  = 1'b1
    } rep_phase_t;

    for (genvar j = 0; j < 2; j++) begin : g_rep
        localparam int CH = (j == 1) ? 4 : 1;

        logic [RW-1:0] rcnt;
        logic [RW-1:0] last;
        rep_phase_t    phase;
        logic          hold;

        assign last = (phase == PH_RATE) ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);

        // hold is false at the press-accept edge because stable is still 0,
        // so the counter starts from zero in the DELAY phase. It is also false
        // at the release-accept edge, which suppresses a pulse that would
        // otherwise fire in that same cycle.
        assign hold = stable[CH] & ~fall[CH];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rcnt  <= '0;
                phase <= PH_DELAY;
            end else if (!hold) begin
                rcnt  <= '0;
                phase <= PH_DELAY;
            end else if (rcnt == last) begin
                rcnt  <= '0;
                phase <= PH_RATE;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end

        assign rep_fire[j] = hold && (rcnt == last);
    end

    assign unused_sig = ^{rise[0], fall[3:2], fall[0]};
`else
    assign rep_fire   = 2'b00;
    assign unused_sig = ^{rise[0], fall, 32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

    // Press and repeat pulses are registered, so no input has a combinational
    // path to an output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_q <= 4'b0000;
        end else begin
            press_q <= rise[4:1] | {rep_fire[1], 2'b00, rep_fire[0]};
        end
    end

    assign btnU     = press_q[3];
    assign btnL     = press_q[2];
    assign btnC     = press_q[1];
    assign btnD     = press_q[0];
    assign door     = stable[0];
    assign btn_held = stable[4:1];

endmodule

// File: tb/tb_microwave_button_conditioner.sv
module tb_microwave_button_conditioner;

  localparam int DB = 8;
  localparam int RD = 40;
  localparam int RR = 10;
  localparam int W  = 36;   // {edge number[31:0], pulse mask {U,L,C,D}}

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btnU_raw = 1'b0, btnL_raw = 1'b0, btnC_raw = 1'b0, btnD_raw = 1'b0;
  logic door_raw = 1'b0;
  logic btnU, btnL, btnC, btnD, door;
  logic [3:0] btn_held;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  logic [W-1:0] exp_q[$];

  microwave_button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset),
    .btnU_raw(btnU_raw), .btnL_raw(btnL_raw), .btnC_raw(btnC_raw),
    .btnD_raw(btnD_raw), .door_raw(door_raw),
    .btnU(btnU), .btnL(btnL), .btnC(btnC), .btnD(btnD),
    .door(door), .btn_held(btn_held)
  );

  // clock / edge counter
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, expv, edge_n);
    end
  endtask

  task automatic wait_until(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic push_pulse(input int e, input logic [3:0] mask);
    exp_q.push_back({32'(e), mask});
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, W'({btnU, btnL, btnC, btnD, door, btn_held}), W'(0));
  endtask

  // scoreboard: every pulse seen must match the next expected entry, and an
  // expected entry whose edge has passed without a pulse is reported as missed
  always @(negedge clk) begin
    logic [3:0] mask;
    logic [W-1:0] e;
    mask = {btnU, btnL, btnC, btnD};
    while (exp_q.size() > 0 && exp_q[0][W-1:4] < 32'(edge_n)) begin
      e = exp_q.pop_front();
      check("pulse_missed", {32'(edge_n), mask}, e);
    end
    if (mask != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("pulse_unexpected", {32'(edge_n), mask}, W'(0));
      end else begin
        e = exp_q.pop_front();
        check("pulse", {32'(edge_n), mask}, e);
      end
    end
  end

  initial begin
    int t0;
    int tr;

    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("after_reset_idle");

    // clean press on C, held 100 cycles
    t0 = edge_n;
    push_pulse(t0 + 10, 4'b0010);
    btnC_raw = 1'b1;
    wait_until(t0 + 9);
    check("c_held_before", W'(btn_held), W'(4'b0000));
    wait_until(t0 + 10);
    check("c_held_after", W'(btn_held), W'(4'b0010));
    wait_until(t0 + 100);
    btnC_raw = 1'b0;
    wait_until(t0 + 109);
    check("c_release_before", W'(btn_held), W'(4'b0010));
    wait_until(t0 + 110);
    check("c_release_after", W'(btn_held), W'(4'b0000));
    wait_until(t0 + 115);

    // bounce on L: high 7 / low 3 for 60 cycles
    t0 = edge_n;
    for (int k = 0; k < 60; k++) begin
      btnL_raw = ((k % 10) < 7);
      @(negedge clk);
    end
    btnL_raw = 1'b0;
    wait_until(t0 + 75);
    check("bounce_held", W'(btn_held), W'(4'b0000));
    // bounce then a final high run of 12 cycles
    for (int k = 0; k < 60; k++) begin
      btnL_raw = ((k % 10) < 7);
      @(negedge clk);
    end
    t0 = edge_n;
    push_pulse(t0 + 10, 4'b0100);
    btnL_raw = 1'b1;
    wait_until(t0 + 12);
    btnL_raw = 1'b0;
    wait_until(t0 + 21);
    check("bounce_final_held", W'(btn_held), W'(4'b0100));
    wait_until(t0 + 22);
    check("bounce_final_release", W'(btn_held), W'(4'b0000));
    wait_until(t0 + 30);

    // door open for 20 cycles, then closed
    t0 = edge_n;
    door_raw = 1'b1;
    wait_until(t0 + 9);
    check("door_before_rise", W'(door), W'(1'b0));
    wait_until(t0 + 10);
    check("door_rise", W'(door), W'(1'b1));
    wait_until(t0 + 20);
    door_raw = 1'b0;
    wait_until(t0 + 29);
    check("door_before_fall", W'(door), W'(1'b1));
    wait_until(t0 + 30);
    check("door_fall", W'(door), W'(1'b0));
    wait_until(t0 + 35);

    // U held 90 cycles (auto-repeat when compiled in)
    t0 = edge_n;
    push_pulse(t0 + 10, 4'b1000);
`ifdef BTN_AUTOREPEAT_EN
    push_pulse(t0 + 10 + RD, 4'b1000);
    for (int r = 1; r <= 4; r++) push_pulse(t0 + 10 + RD + r * RR, 4'b1000);
`endif
    btnU_raw = 1'b1;
    wait_until(t0 + 90);
    btnU_raw = 1'b0;
    wait_until(t0 + 99);
    check("u_held_before_release", W'(btn_held), W'(4'b1000));
    wait_until(t0 + 100);
    check("u_released", W'(btn_held), W'(4'b0000));
    wait_until(t0 + 120);

    // reset mid-debounce with D held
    t0 = edge_n;
    btnD_raw = 1'b1;
    wait_until(t0 + 6);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_1");
    @(negedge clk);
    check_all_zero("reset_mid_2");
    wait_until(t0 + 9);
    check_all_zero("reset_mid_3");
    tr = edge_n;
    reset = 1'b0;
    push_pulse(tr + 10, 4'b0001);
    wait_until(tr + 10);
    check("d_held_after_reset", W'(btn_held), W'(4'b0001));
    wait_until(tr + 30);
    btnD_raw = 1'b0;
    wait_until(tr + 45);
    check("d_released", W'(btn_held), W'(4'b0000));

    // simultaneous U and D
    t0 = edge_n;
    push_pulse(t0 + 10, 4'b1001);
    btnU_raw = 1'b1;
    btnD_raw = 1'b1;
    wait_until(t0 + 10);
    check("simul_held", W'(btn_held), W'(4'b1001));
    wait_until(t0 + 20);
    btnU_raw = 1'b0;
    btnD_raw = 1'b0;
    wait_until(t0 + 35);
    check("simul_released", W'(btn_held), W'(4'b0000));

    // every expected pulse must have been consumed
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
